coin_credit_unit: RTL
=====================

# coin_credit_unit

Downstream consumer of the four-key debouncer in the candy vending machine. Takes the four debounced key levels and converts rising edges into coin events (5, 10, 25) and a select event. Accumulates credit, requests a vend from the dispenser FSM with a req/ack handshake, and returns change. Sits between the debouncer and the dispense/display logic.

## Interface
- `PRICE`, default 50: candy price in cents.
- `MAX_CREDIT`, default 200: highest credit accepted; must be less than 2^`CREDIT_W` and at least `PRICE`.
- `CREDIT_W`, default 8: width of the credit and change registers.
- `clk` in 1: system clock; all state updates on its rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `key_in` in 4: debounced key levels.
  - bit0 = 5-cent coin.
  - bit1 = 10-cent coin.
  - bit2 = 25-cent coin.
  - bit3 = select.
- `vend_ack` in 1: dispenser accepted the vend; sampled only in VEND.
- `credit` out `CREDIT_W`: current accumulated credit.
- `vend_req` out 1: level; high throughout VEND.
- `change` out `CREDIT_W`: refund amount; valid only while `change_valid` is high.
- `change_valid` out 1: one-cycle pulse.
- `coin_reject` out 1: one-cycle pulse; a coin event was refused.
- `short_credit` out 1: one-cycle pulse; select pressed with credit below `PRICE`.

## Operation
- Edge detect:
  - `key_q` registers `key_in` every cycle.
  - `rise = key_in & ~key_q`.
  - `key_q` resets to 4'b1111, so keys held through reset release produce no event.
- States: IDLE (credit 0), ACCUM (credit > 0), VEND, CHANGE.
- Coin event: exactly one of `rise[2:0]` set, in IDLE or ACCUM.
  - If `credit + value <= MAX_CREDIT`: add the value to `credit`; IDLE goes to ACCUM.
  - Otherwise: `credit` unchanged and `coin_reject` pulses.
- Two or more of `rise[2:0]` in the same cycle: all are refused, one `coin_reject` pulse, credit unchanged.
- Any coin rise in VEND or CHANGE: `coin_reject` pulses.
- Select (`rise[3]`) in IDLE or ACCUM:
  - `credit >= PRICE`: go to VEND.
  - Otherwise: pulse `short_credit` (see Configuration).
- Select and coin rises in the same cycle: the coin is evaluated first. Select then compares against the updated credit, all in one cycle.
- VEND:
  - `vend_req` = 1.
  - On `vend_ack`: `change <= credit - PRICE`, `credit <= 0`, go to CHANGE.
  - Select rises are ignored.
- CHANGE: `change_valid` = 1 for exactly this one cycle, then IDLE. `change` holds its value until it is next loaded.
- `change` is loaded even when zero; `change_valid` still pulses.
- `vend_ack` outside VEND is ignored.
- Arithmetic: the sum is computed at `CREDIT_W+1` bits before the `MAX_CREDIT` compare, so there is no wrap-around. The subtraction cannot underflow because VEND requires `credit >= PRICE`.

## Timing
- Reset values: state IDLE, `credit` 0, `change` 0, `vend_req` 0, `change_valid` 0, `coin_reject` 0, `short_credit` 0, `key_q` 4'b1111.
- `key_in` first sampled high at edge k: `credit`, `coin_reject` and `short_credit` update at edge k, and state enters VEND at edge k.
- `vend_req` is high in the cycle after edge k.
- `vend_ack` sampled high at edge m: `vend_req` falls and `change_valid` rises after edge m. `change_valid` falls after edge m+1.
- All outputs are registered.
- Reset asserted mid-operation (including VEND): everything returns to reset values immediately. Credit is discarded and no change is issued.
- A key held high produces only one event. A new event requires a low sample first.

## Configuration
- `CREDIT_CANCEL_EN` defined: select in ACCUM with `credit < PRICE` refunds the credit.
  - `change <= credit`, `credit <= 0`, state goes to CHANGE.
  - `change_valid` pulses the next cycle; `short_credit` also pulses.
- `CREDIT_CANCEL_EN` undefined: that select only pulses `short_credit`; credit and state are unchanged.
- Select in IDLE pulses `short_credit` only, in both builds.

## Test plan
- Reset release with `key_in`=4'b0100 held, then release and press bit2 again -> no event at release, `credit`=25 after the second press; no `coin_reject`.
- Coins 25, 25, then select, then `vend_ack` 3 cycles after `vend_req` rises -> `vend_req` high 3 cycles, then `change_valid` for 1 cycle with `change`=0, `credit`=0, state IDLE.
- Coins 25, 25, 10, then select, `vend_ack` -> `change`=10.
- Credit 195, then a 10 coin -> `coin_reject` pulse, credit stays 195. Bits 0 and 1 rising in the same cycle -> one `coin_reject`, credit unchanged.
- Credit 30, then select -> `short_credit` pulse.
  - With `CREDIT_CANCEL_EN`: `change`=30 with `change_valid`, credit 0.
  - Without: credit stays 30.
- Reset asserted during VEND with credit 75 -> `vend_req` and `credit` go to 0 asynchronously; no `change_valid` after release.

Source files
------------

// File: rtl/coin_credit_unit_if.sv
// Key/vend/change signal bundle between the coin credit unit and its neighbours.
// master drives keys and vend_ack; slave is the credit unit itself.
interface coin_credit_unit_if #(
    parameter int CREDIT_W = 8
);
    logic [3:0]          key_in;
    logic                vend_ack;
    logic [CREDIT_W-1:0] credit;
    logic                vend_req;
    logic [CREDIT_W-1:0] change;
    logic                change_valid;
    logic                coin_reject;
    logic                short_credit;

    modport master (
        output key_in, vend_ack,
        input  credit, vend_req, change, change_valid, coin_reject, short_credit
    );

    modport slave (
        input  key_in, vend_ack,
        output credit, vend_req, change, change_valid, coin_reject, short_credit
    );
endinterface

// File: rtl/coin_credit_unit.sv
// Coin credit accumulator: key rising edges -> coin/select events, vend req/ack, change return.
// Latency: outputs registered, one edge after the key sample; optional refund-on-select via CREDIT_CANCEL_EN.
// Backpressure: vend_req is held until vend_ack; coins arriving while vending are refused.
module coin_credit_unit #(
    parameter int PRICE      = 50,
    parameter int MAX_CREDIT = 200,
    parameter int CREDIT_W   = 8
) (
    input logic               clk,
    input logic               reset,
    coin_credit_unit_if.slave bus
);

    typedef enum logic [1:0] {IDLE, ACCUM, VEND, CHANGE} state_t;

    localparam logic [CREDIT_W:0]   MAX_W   = (CREDIT_W+1)'(MAX_CREDIT);
    localparam logic [CREDIT_W-1:0] PRICE_W = CREDIT_W'(PRICE);

    state_t              state, state_nxt;
    logic [3:0]          key_q;
    logic [3:0]          rise;
    logic                multi_coin;
    logic                any_coin;
    logic [CREDIT_W:0]   coin_val;
    logic [CREDIT_W:0]   sum;

    logic [CREDIT_W-1:0] credit_r, credit_nxt;
    logic [CREDIT_W-1:0] change_r, change_nxt;
    logic                vend_req_r;
    logic                change_valid_r;
    logic                reject_r, reject_nxt;
    logic                short_r, short_nxt;

    assign rise       = bus.key_in & ~key_q;
    assign any_coin   = |rise[2:0];
    assign multi_coin = (rise[0] & rise[1]) | (rise[0] & rise[2]) | (rise[1] & rise[2]);

    always_comb begin
        coin_val = '0;
        if (rise[0])      coin_val = (CREDIT_W+1)'(5);
        else if (rise[1]) coin_val = (CREDIT_W+1)'(10);
        else if (rise[2]) coin_val = (CREDIT_W+1)'(25);
    end

    // One extra bit so an over-limit sum can never wrap below MAX_CREDIT.
    assign sum = {1'b0, credit_r} + coin_val;

    always_comb begin
        state_nxt  = state;
        credit_nxt = credit_r;
        change_nxt = change_r;
        reject_nxt = 1'b0;
        short_nxt  = 1'b0;
        case (state)
            IDLE, ACCUM: begin
                if (multi_coin) begin
                    reject_nxt = 1'b1;
                end else if (any_coin) begin
                    if (sum <= MAX_W) credit_nxt = sum[CREDIT_W-1:0];
                    else              reject_nxt = 1'b1;
                end
                state_nxt = (credit_nxt == '0) ? IDLE : ACCUM;
                // Select sees the credit including any coin accepted this same cycle.
                if (rise[3]) begin
                    if (credit_nxt >= PRICE_W) begin
                        state_nxt = VEND;
                    end else begin
                        short_nxt = 1'b1;
`ifdef CREDIT_CANCEL_EN
                        if (credit_nxt != '0) begin
                            change_nxt = credit_nxt;
                            credit_nxt = '0;
                            state_nxt  = CHANGE;
                        end
`endif
                    end
                end
            end
            VEND: begin
                reject_nxt = any_coin;
                if (bus.vend_ack) begin
                    change_nxt = credit_r - PRICE_W;
                    credit_nxt = '0;
                    state_nxt  = CHANGE;
                end
            end
            CHANGE: begin
                reject_nxt = any_coin;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // key_q resets high so keys held through reset release do not count as presses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            key_q          <= 4'b1111;
            credit_r       <= '0;
            change_r       <= '0;
            vend_req_r     <= 1'b0;
            change_valid_r <= 1'b0;
            reject_r       <= 1'b0;
            short_r        <= 1'b0;
        end else begin
            state          <= state_nxt;
            key_q          <= bus.key_in;
            credit_r       <= credit_nxt;
            change_r       <= change_nxt;
            vend_req_r     <= (state_nxt == VEND);
            change_valid_r <= (state_nxt == CHANGE);
            reject_r       <= reject_nxt;
            short_r        <= short_nxt;
        end
    end

    assign bus.credit       = credit_r;
    assign bus.change       = change_r;
    assign bus.vend_req     = vend_req_r;
    assign bus.change_valid = change_valid_r;
    assign bus.coin_reject  = reject_r;
    assign bus.short_credit = short_r;

endmodule
